// File: rtl/pla_sched_pkg.sv
// rtl/pla_sched_pkg.sv - shared types and default sizes for the PLA cube scheduler
package pla_sched_pkg;

    localparam int DEF_N_IN    = 12;
    localparam int DEF_N_CUBES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // One product term. Only bits with care=1 are compared against val.
    typedef struct packed {
        logic                en;
        logic [DEF_N_IN-1:0] care;
        logic [DEF_N_IN-1:0] val;
    } cube_t;

endpackage

// File: rtl/pla_cube_match.sv
// rtl/pla_cube_match.sv - combinational single-cube comparator
//   x     : input vector
//   cube  : cube under test (en, care, val)
//   match : 1 when cube is enabled and every cared bit of x equals val
module pla_cube_match
    import pla_sched_pkg::*;
(
    input  logic [DEF_N_IN-1:0] x,
    input  cube_t               cube,
    output logic                match
);

    assign match = cube.en && (((x ^ cube.val) & cube.care) == '0);

endmodule

// File: rtl/pla_cube_scheduler.sv
// rtl/pla_cube_scheduler.sv - time-shared PLA evaluator, one cube per cycle, first match wins
//   clk, rst                       : clock, async active-high reset
//   cfg_we/cfg_ready/cfg_idx/...   : cube table write port, accepted only in IDLE
//   in_valid/in_ready/in_x         : input vector handshake
//   out_valid/out_ready/out_y/out_idx : result handshake, held in DONE until taken
//   hit_cnt                        : saturating count of handed-off results with out_y=1
module pla_cube_scheduler
    import pla_sched_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_CUBES = DEF_N_CUBES,
    parameter int CIDX_W  = $clog2(N_CUBES),
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    output logic              cfg_ready,
    input  logic [CIDX_W-1:0] cfg_idx,
    input  logic              cfg_en,
    input  logic [N_IN-1:0]   cfg_care,
    input  logic [N_IN-1:0]   cfg_val,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic [CIDX_W-1:0] out_idx,
    output logic [CNT_W-1:0]  hit_cnt
);

    state_t            state;
    cube_t             tbl [N_CUBES];
    logic [CIDX_W-1:0] idx;
    logic [N_IN-1:0]   x_q;
    logic              cur_match;

    assign in_ready  = (state == IDLE);
    assign cfg_ready = (state == IDLE);
    assign out_valid = (state == DONE);

    pla_cube_match u_match (
        .x     (x_q),
        .cube  (tbl[idx]),
        .match (cur_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            x_q     <= '0;
            out_y   <= 1'b0;
            out_idx <= '0;
            hit_cnt <= '0;
            for (int k = 0; k < N_CUBES; k++) begin
                tbl[k] <= '0;
            end
        end else begin
            // Table write commits in IDLE; the scan starts on the following
            // cycle, so a same-cycle accept already sees the new entry.
            if (cfg_we && state == IDLE) begin
                tbl[cfg_idx] <= '{en: cfg_en, care: cfg_care, val: cfg_val};
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q   <= in_x;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_match) begin
                        out_y   <= 1'b1;
                        out_idx <= idx;
                        state   <= DONE;
                    end else if (idx == CIDX_W'(N_CUBES - 1)) begin
                        out_y   <= 1'b0;
                        out_idx <= '0;
                        state   <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        if (out_y && hit_cnt != {CNT_W{1'b1}}) begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pla_cube_scheduler.sv
// tb/tb_pla_cube_scheduler.sv - self-checking bench for pla_cube_scheduler
module tb_pla_cube_scheduler;

    localparam int NI    = 12;
    localparam int NC    = 16;
    localparam int CW    = 4;
    localparam int HW    = 4;
    localparam int HMAX  = 15;
    localparam int LIMIT = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_idx = '0;
    logic          cfg_en = 1'b0;
    logic [NI-1:0] cfg_care = '0;
    logic [NI-1:0] cfg_val = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NI-1:0] in_x = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_y;
    logic [CW-1:0] out_idx;
    logic [HW-1:0] hit_cnt;

    int checks = 0;
    int errors = 0;

    bit            m_en   [NC];
    logic [NI-1:0] m_care [NC];
    logic [NI-1:0] m_val  [NC];
    int            m_hits = 0;

    always #5 clk = ~clk;

    pla_cube_scheduler #(.CNT_W(HW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_en    (cfg_en),
        .cfg_care  (cfg_care),
        .cfg_val   (cfg_val),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_idx   (out_idx),
        .hit_cnt   (hit_cnt)
    );

    // Reference: first enabled cube whose cared bits agree with x.
    task automatic ref_eval(input logic [NI-1:0] x, output logic y, output int k_hit, output int lat);
        k_hit = -1;
        for (int k = 0; k < NC; k++) begin
            if (k_hit < 0 && m_en[k] && (((x ^ m_val[k]) & m_care[k]) == 0)) k_hit = k;
        end
        y   = (k_hit >= 0);
        lat = (k_hit >= 0) ? k_hit + 1 : NC;
        if (k_hit < 0) k_hit = 0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NC; k++) begin
            m_en[k] = 0; m_care[k] = '0; m_val[k] = '0;
        end
        m_hits = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic cfg_write(input int k, input bit en, input logic [NI-1:0] care, input logic [NI-1:0] val);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = CW'(k); cfg_en = en; cfg_care = care; cfg_val = val;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        m_en[k] = en; m_care[k] = care; m_val[k] = val;
    endtask

    task automatic start_query(input logic [NI-1:0] x);
        @(negedge clk);
        in_valid = 1'b1; in_x = x;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_x = NI'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handoff(input logic exp_y);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        if (exp_y && m_hits < HMAX) m_hits++;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
        checks++; if (out_y !== 1'b0 || out_idx !== '0) begin errors++; $display("FAIL reset_out got y=%b idx=%0d want 0/0", out_y, out_idx); end
        checks++; if (hit_cnt !== '0) begin errors++; $display("FAIL reset_hit_cnt got %0d want 0", hit_cnt); end
    endtask

    task automatic query_check(input string name, input logic [NI-1:0] x);
        logic ey; int ek, el, lat;
        ref_eval(x, ey, ek, el);
        start_query(x);
        wait_done(lat);
        checks++;
        if (lat !== el || out_y !== ey || out_idx !== CW'(ek)) begin
            errors++;
            $display("FAIL %s x=%h got lat=%0d y=%b idx=%0d want lat=%0d y=%b idx=%0d",
                     name, x, lat, out_y, out_idx, el, ey, ek);
        end
        if (lat != 0) handoff(ey);
        checks++;
        if (hit_cnt !== HW'(m_hits)) begin
            errors++; $display("FAIL %s_hit_cnt got %0d want %0d", name, hit_cnt, m_hits);
        end
    endtask

    task automatic test_full_cube();
        cfg_write(0, 1, 12'hFFF, 12'hECE);
        query_check("full_hit", 12'hECE);
        query_check("full_miss", 12'hECF);
    endtask

    task automatic test_priority();
        cfg_write(3, 1, 12'h00F, 12'h005);
        cfg_write(7, 1, 12'h000, 12'h000);
        query_check("prio_slot3", 12'h125);
        query_check("prio_slot7", 12'h120);
    endtask

    task automatic test_disabled();
        do_reset();
        cfg_write(0, 0, 12'h000, 12'h000);
        query_check("disabled_a", NI'($urandom));
        query_check("disabled_b", NI'($urandom));
    endtask

    task automatic test_backpressure();
        int lat;
        start_query(12'h5A5);
        wait_done(lat);
        checks++; if (lat !== NC) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, NC); end
        cfg_we = 1'b1; cfg_idx = CW'(5); cfg_en = 1'b1; cfg_care = '0; cfg_val = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_y !== 1'b0 || out_idx !== '0 || in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b y=%b idx=%0d ir=%b cr=%b want 1 0 0 0 0",
                         i, out_valid, out_y, out_idx, in_ready, cfg_ready);
            end
        end
        cfg_we = 1'b0;
        handoff(1'b0);
        query_check("bp_slot5_unchanged", NI'($urandom));
    endtask

    task automatic test_same_cycle();
        int lat;
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = '0; cfg_en = 1'b1; cfg_care = 12'hFFF; cfg_val = 12'h123;
        in_valid = 1'b1; in_x = 12'h123;
        @(posedge clk);
        #1 cfg_we = 1'b0; in_valid = 1'b0; in_x = 12'h000;
        m_en[0] = 1; m_care[0] = 12'hFFF; m_val[0] = 12'h123;
        wait_done(lat);
        checks++;
        if (lat !== 1 || out_y !== 1'b1 || out_idx !== '0) begin
            errors++; $display("FAIL same_cycle got lat=%0d y=%b idx=%0d want 1 1 0", lat, out_y, out_idx);
        end
        if (lat != 0) handoff(1'b1);
        checks++;
        if (hit_cnt !== HW'(m_hits)) begin errors++; $display("FAIL same_cycle_hit_cnt got %0d want %0d", hit_cnt, m_hits); end
    endtask

    task automatic test_reset_mid_scan();
        checks++; if (hit_cnt === '0) begin errors++; $display("FAIL pre_reset_hit_cnt got 0 want nonzero"); end
        start_query(12'h000);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midscan_rst got v=%b ir=%b want 0 1", out_valid, in_ready); end
        checks++; if (hit_cnt !== '0) begin errors++; $display("FAIL midscan_rst_hit_cnt got %0d want 0", hit_cnt); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        query_check("table_cleared", 12'h123);
    endtask

    task automatic test_saturation();
        cfg_write(0, 1, 12'h000, 12'h000);
        for (int i = 0; i < 17; i++) query_check("sat", NI'($urandom));
        checks++; if (hit_cnt !== 4'd15) begin errors++; $display("FAIL sat_final got %0d want 15", hit_cnt); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int w = 0; w < 8; w++) begin
                cfg_write($urandom_range(NC - 1), $urandom_range(3) != 0,
                          NI'($urandom & $urandom & $urandom), NI'($urandom));
            end
            for (int q = 0; q < 24; q++) query_check("random", NI'($urandom));
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_full_cube();
        test_priority();
        test_disabled();
        test_backpressure();
        test_same_cycle();
        test_reset_mid_scan();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
